seg7_scan: RTL and testbench

Four-digit, time-multiplexed seven-segment driver for the Hanoi tower board, directly downstream of the clock divider. It runs on the 100 MHz master clock and treats the divider's 500 Hz refresh square wave and 5 Hz blink square wave as asynchronous level inputs, which it synchronizes internally. From these it scans four hex digits onto the shared active-low cathodes and anodes, with per-digit blink and blank masks and an anti-ghosting blank gap between digits.

---
 rtl/seg7_scan.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: synchronizes refresh/blink square waves and scans
// a snapshotted frame of hex digits onto active-low anodes/cathodes with an anti-ghosting gap.
module seg7_scan #(
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        master_clk,
    input  logic        rst_n,
    input  logic        refresh_in,
    input  logic        blink_in,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an
);

    typedef enum logic {StBlank, StShow} state_e;

    localparam logic [15:0] BlankLast = 16'(BLANK_CYCLES - 1);

    logic        ref_s1_q, ref_s2_q, ref_s3_q;
    logic        blk_s1_q, blk_s2_q;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        first_q, first_d;
    logic [15:0] fr_digits_q, fr_digits_d;
    logic [3:0]  fr_blink_q, fr_blink_d;
    logic [3:0]  fr_blank_q, fr_blank_d;
    logic [3:0]  fr_dp_q, fr_dp_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_n_q, dp_n_d;
    logic [3:0]  an_q, an_d;
    logic        refresh_pulse;
    logic        snap;
    logic        dark;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign refresh_pulse = ref_s2_q & ~ref_s3_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        first_d     = first_q;
        snap        = 1'b0;
        fr_digits_d = fr_digits_q;
        fr_blink_d  = fr_blink_q;
        fr_blank_d  = fr_blank_q;
        fr_dp_d     = fr_dp_q;

        if (refresh_pulse) begin
            // An edge always restarts the gap, even mid-gap, so a too-fast refresh stays dark
            idx_d   = idx_q + 2'd1;
            state_d = StBlank;
            cnt_d   = '0;
            snap    = (idx_q == 2'd3);
        end else if (state_q == StBlank) begin
            if (cnt_q == BlankLast) begin
                state_d = StShow;
                cnt_d   = '0;
                if (first_q) begin
                    snap    = 1'b1;
                    first_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        if (snap) begin
            fr_digits_d = digits;
            fr_blink_d  = blink_mask;
            fr_blank_d  = blank_mask;
            fr_dp_d     = dp_mask;
        end
    end

    // Outputs are precomputed from next-state values so the display register tracks the FSM
    always_comb begin
        an_d   = 4'b1111;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        dark   = fr_blank_d[idx_d] | (fr_blink_d[idx_d] & blk_s2_q);
        if (state_d == StShow) begin
            an_d = ~(4'b0001 << idx_d);
            if (!dark) begin
                seg_d  = hex_to_seg(fr_digits_d[{idx_d, 2'b00} +: 4]);
                dp_n_d = ~fr_dp_d[idx_d];
            end
        end
    end

    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_s1_q    <= 1'b0;
            ref_s2_q    <= 1'b0;
            ref_s3_q    <= 1'b0;
            blk_s1_q    <= 1'b0;
            blk_s2_q    <= 1'b0;
            state_q     <= StBlank;
            cnt_q       <= '0;
            idx_q       <= '0;
            first_q     <= 1'b1;
            fr_digits_q <= '0;
            fr_blink_q  <= '0;
            fr_blank_q  <= '0;
            fr_dp_q     <= '0;
            seg_q       <= 7'h7F;
            dp_n_q      <= 1'b1;
            an_q        <= 4'b1111;
        end else begin
            ref_s1_q    <= refresh_in;
            ref_s2_q    <= ref_s1_q;
            ref_s3_q    <= ref_s2_q;
            blk_s1_q    <= blink_in;
            blk_s2_q    <= blk_s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            fr_digits_q <= fr_digits_d;
            fr_blink_q  <= fr_blink_d;
            fr_blank_q  <= fr_blank_d;
            fr_dp_q     <= fr_dp_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
            an_q        <= an_d;
        end
    end

    assign seg  = seg_q;
    assign dp_n = dp_n_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with BLANK_CYCLES=4: start-up, scan order, snapshot, masks,
// blink latency, fast refresh and asynchronous mid-scan reset.
module tb_seg7_scan;

    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] SF   = 7'b0001110;
    localparam logic [6:0] DARK = 7'h7F;

    logic        clk;
    logic        rst_n;
    logic        refresh_in;
    logic        blink_in;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  bmask;
        logic [3:0]  kmask;
        logic [3:0]  dmask;
        logic        blink;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [12];

    seg7_scan #(.BLANK_CYCLES(4)) dut (
        .master_clk (clk),
        .rst_n      (rst_n),
        .refresh_in (refresh_in),
        .blink_in   (blink_in),
        .digits     (digits),
        .blink_mask (blink_mask),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One rising refresh edge; outputs dark from edge N+2 through N+5, digit at N+6
    task automatic step(input int k);
        digits     = vecs[k].dig;
        blink_mask = vecs[k].bmask;
        blank_mask = vecs[k].kmask;
        dp_mask    = vecs[k].dmask;
        blink_in   = vecs[k].blink;
        refresh_in = 1'b1;
        tick();
        tick();
        tick();
        check($sformatf("v%0d_gap_start_an", k), 32'(an), 32'hF);
        check($sformatf("v%0d_gap_start_seg", k), 32'(seg), 32'(DARK));
        tick();
        tick();
        tick();
        check($sformatf("v%0d_gap_end_an", k), 32'(an), 32'hF);
        tick();
        check($sformatf("v%0d_an", k), 32'(an), 32'(vecs[k].exp_an));
        check($sformatf("v%0d_seg", k), 32'(seg), 32'(vecs[k].exp_seg));
        check($sformatf("v%0d_dp_n", k), 32'(dp_n), 32'(vecs[k].exp_dp));
        repeat (20) tick();
        refresh_in = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        //          digits    blink  blank  dp     blk   an       seg   dp_n
        vecs[0]  = '{16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1101, S2,   1'b1};
        vecs[1]  = '{16'h4321, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1011, S3,   1'b1};
        vecs[2]  = '{16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b0, 4'b0111, S4,   1'b1};
        vecs[3]  = '{16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1110, SF,   1'b1};
        vecs[4]  = '{16'hFFFF, 4'h0, 4'h0, 4'h0, 1'b0, 4'b1101, SF,   1'b1};
        vecs[5]  = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b1, 4'b1011, SF,   1'b1};
        vecs[6]  = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b1, 4'b0111, SF,   1'b1};
        vecs[7]  = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b1, 4'b1110, DARK, 1'b1};
        vecs[8]  = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b1, 4'b1101, S2,   1'b0};
        vecs[9]  = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b1, 4'b1011, S3,   1'b1};
        vecs[10] = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b1, 4'b0111, DARK, 1'b1};
        vecs[11] = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b0, 4'b1110, S1,   1'b1};

        rst_n      = 1'b0;
        refresh_in = 1'b0;
        blink_in   = 1'b0;
        digits     = 16'h4321;
        blink_mask = 4'h0;
        blank_mask = 4'h0;
        dp_mask    = 4'h0;

        // Start-up
        repeat (3) tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'(DARK));
        check("rst_dp_n", 32'(dp_n), 32'h1);
        rst_n = 1'b1;
        repeat (3) tick();
        check("startup_edge3_an", 32'(an), 32'hF);
        tick();
        check("startup_edge4_an", 32'(an), 32'hE);
        check("startup_edge4_seg", 32'(seg), 32'(S1));
        repeat (10) tick();

        // Scan order, snapshot and masks
        for (int k = 0; k < 12; k++) step(k);

        // Blink latency: digit 0 lit for 2 edges after blink rises, dark on the 3rd
        blink_in = 1'b1;
        tick();
        tick();
        check("blink_edge2_seg", 32'(seg), 32'(S1));
        tick();
        check("blink_edge3_seg", 32'(seg), 32'(DARK));
        check("blink_edge3_an", 32'(an), 32'hE);
        blink_in = 1'b0;
        repeat (5) tick();
        check("unblink_seg", 32'(seg), 32'(S1));

        // Fast refresh: 21 rising edges, display must stay dark, idx ends at 1
        begin
            int dark_bad;
            dark_bad = 0;
            for (int t = 0; t < 42; t++) begin
                refresh_in = ~refresh_in;
                repeat (2) begin
                    tick();
                    if (t >= 2 && an !== 4'hF) dark_bad++;
                end
            end
            check("fast_refresh_dark_cycles", 32'(dark_bad), 32'h0);
        end
        repeat (10) tick();
        check("fast_recover_an", 32'(an), 32'hD);
        check("fast_recover_seg", 32'(seg), 32'(S2));
        check("fast_recover_dp_n", 32'(dp_n), 32'h0);
        vecs[0] = '{16'h4321, 4'h1, 4'h8, 4'h2, 1'b0, 4'b1011, S3, 1'b1};
        step(0);

        // Asynchronous reset while digit 2 is shown
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'(DARK));
        check("midrst_dp_n", 32'(dp_n), 32'h1);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("restart_edge3_an", 32'(an), 32'hF);
        tick();
        check("restart_edge4_an", 32'(an), 32'hE);
        check("restart_edge4_seg", 32'(seg), 32'(S1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
